// File: rtl/decomp_pkg.sv
// Shared defaults and word-index decode for the two-bank decompressor dictionary.
package decomp_pkg;

    localparam int unsigned DefDataWidth  = 32;
    localparam int unsigned DefSize       = 8;
    localparam int unsigned DefTotalWords = 2 * DefSize;

    typedef enum logic {
        Bank1 = 1'b0,
        Bank2 = 1'b1
    } bank_sel_e;

    // Even word indices live in bank 1, odd ones in bank 2, both at slot k>>1.
    function automatic bank_sel_e idx_bank(input int unsigned idx);
        return bank_sel_e'(idx[0]);
    endfunction

    function automatic int unsigned idx_slot(input int unsigned idx);
        return idx >> 1;
    endfunction

endpackage

// File: rtl/dict_bank.sv
// One dictionary bank: storage, per-entry valid bits, wrapping write pointer and
// two combinational read ports (one per lookup lane).
module dict_bank #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SIZE       = 8,
    localparam int unsigned SW        = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] w_data_i,
    input  logic [SW-1:0]         rd_slot_a_i,
    input  logic [SW-1:0]         rd_slot_b_i,
    output logic [DATA_WIDTH-1:0] rd_data_a_o,
    output logic                  rd_valid_a_o,
    output logic [DATA_WIDTH-1:0] rd_data_b_o,
    output logic                  rd_valid_b_o
);

    logic [DATA_WIDTH-1:0] mem_q [SIZE];
    logic [SIZE-1:0]       valid_q;
    logic [SW-1:0]         ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (wr_i) begin
            ptr_d = (ptr_q == SW'(SIZE - 1)) ? '0 : ptr_q + SW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < SIZE; i++) begin
                mem_q[i] <= '0;
            end
            valid_q <= '0;
            ptr_q   <= '0;
        end else begin
            if (wr_i) begin
                mem_q[ptr_q]   <= w_data_i;
                valid_q[ptr_q] <= 1'b1;
            end
            ptr_q <= ptr_d;
        end
    end

    // Unwritten entries read as zero regardless of storage contents.
    always_comb begin
        rd_valid_a_o = valid_q[rd_slot_a_i];
        rd_valid_b_o = valid_q[rd_slot_b_i];
        rd_data_a_o  = rd_valid_a_o ? mem_q[rd_slot_a_i] : '0;
        rd_data_b_o  = rd_valid_b_o ? mem_q[rd_slot_b_i] : '0;
    end

endmodule

// File: rtl/decomp_dict.sv
// Decompressor dictionary mirroring the compressor's two-bank layout, with a
// single-stage registered two-lane lookup behind a valid/ready handshake.
module decomp_dict
    import decomp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DefDataWidth,
    parameter int unsigned SIZE        = DefSize,
    parameter int unsigned TOTAL_WORDS = DefTotalWords,
    localparam int unsigned IW         = $clog2(TOTAL_WORDS)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  wr,
    input  logic                  wr2,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [DATA_WIDTH-1:0] w_data2,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [IW-1:0]         req_idx,
    input  logic [IW-1:0]         req_idx2,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [DATA_WIDTH-1:0] rsp_data2,
    output logic [1:0]            rsp_err
);

    localparam int unsigned SW = (SIZE > 1) ? $clog2(SIZE) : 1;

    bank_sel_e             sel1, sel2;
    logic [SW-1:0]         slot1, slot2;
    logic [DATA_WIDTH-1:0] b1_data_a, b1_data_b, b2_data_a, b2_data_b;
    logic                  b1_valid_a, b1_valid_b, b2_valid_a, b2_valid_b;
    logic [DATA_WIDTH-1:0] lane1_data, lane2_data;
    logic                  lane1_ok, lane2_ok;
    logic                  accept;

    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [DATA_WIDTH-1:0] rsp_data2_q, rsp_data2_d;
    logic [1:0]            rsp_err_q, rsp_err_d;

    always_comb begin
        sel1  = idx_bank(32'(req_idx));
        sel2  = idx_bank(32'(req_idx2));
        slot1 = SW'(idx_slot(32'(req_idx)));
        slot2 = SW'(idx_slot(32'(req_idx2)));
    end

    // Port a serves lane 1 and port b serves lane 2 in both banks.
    dict_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIZE       (SIZE)
    ) u_bank1 (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .wr_i         (wr),
        .w_data_i     (w_data),
        .rd_slot_a_i  (slot1),
        .rd_slot_b_i  (slot2),
        .rd_data_a_o  (b1_data_a),
        .rd_valid_a_o (b1_valid_a),
        .rd_data_b_o  (b1_data_b),
        .rd_valid_b_o (b1_valid_b)
    );

    dict_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIZE       (SIZE)
    ) u_bank2 (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .wr_i         (wr2),
        .w_data_i     (w_data2),
        .rd_slot_a_i  (slot1),
        .rd_slot_b_i  (slot2),
        .rd_data_a_o  (b2_data_a),
        .rd_valid_a_o (b2_valid_a),
        .rd_data_b_o  (b2_data_b),
        .rd_valid_b_o (b2_valid_b)
    );

    always_comb begin
        lane1_data = (sel1 == Bank2) ? b2_data_a : b1_data_a;
        lane1_ok   = (sel1 == Bank2) ? b2_valid_a : b1_valid_a;
        lane2_data = (sel2 == Bank2) ? b2_data_b : b1_data_b;
        lane2_ok   = (sel2 == Bank2) ? b2_valid_b : b1_valid_b;
    end

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign accept    = req_valid && req_ready;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_data2_d = rsp_data2_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = lane1_data;
            rsp_data2_d = lane2_data;
            rsp_err_d   = {!lane2_ok, !lane1_ok};
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_data2_q <= '0;
            rsp_err_q   <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_data2_q <= rsp_data2_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_data2 = rsp_data2_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_decomp_dict.sv
// Self-checking bench for decomp_dict: directed corner cases, a vector table and
// randomized traffic against a word-indexed dictionary model with a response queue.
module tb_decomp_dict;

    localparam int DW    = 32;
    localparam int SZ    = 8;
    localparam int WORDS = 2 * SZ;
    localparam int IW    = 4;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          wr, wr2;
    logic [DW-1:0] w_data, w_data2;
    logic          req_valid, req_ready;
    logic [IW-1:0] req_idx, req_idx2;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data, rsp_data2;
    logic [1:0]    rsp_err;

    decomp_dict u_dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .wr        (wr),
        .wr2       (wr2),
        .w_data    (w_data),
        .w_data2   (w_data2),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_idx   (req_idx),
        .req_idx2  (req_idx2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_data2 (rsp_data2),
        .rsp_err   (rsp_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [1:0]    err;
    } rsp_t;

    typedef struct {
        int            idx;
        int            idx2;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [1:0]    err;
    } vec_t;

    // Model: dictionary viewed by word index; bank1 slot p = word 2p, bank2 slot p = word 2p+1.
    logic [DW-1:0] dict [WORDS];
    bit            dv   [WORDS];
    int            p1, p2;
    rsp_t          rq[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rsp_t lookup(input int a, input int b);
        rsp_t r;
        r.d1  = dv[a] ? dict[a] : '0;
        r.d2  = dv[b] ? dict[b] : '0;
        r.err = {!dv[b], !dv[a]};
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < WORDS; k++) begin
            dict[k] = '0;
            dv[k]   = 1'b0;
        end
        p1 = 0;
        p2 = 0;
        rq.delete();
    endtask

    // Inputs are already set; check current outputs, predict the edge, advance.
    task automatic tick();
        bit   exp_rr;
        rsp_t r;
        #1;
        exp_rr = (rq.size() == 0) || rsp_ready;
        chk("req_ready", {31'd0, req_ready}, {31'd0, exp_rr});
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, rq.size() != 0});
        if (rq.size() != 0) begin
            chk("rsp_data", rsp_data, rq[0].d1);
            chk("rsp_data2", rsp_data2, rq[0].d2);
            chk("rsp_err", {30'd0, rsp_err}, {30'd0, rq[0].err});
        end
        if (rq.size() != 0 && rsp_ready) void'(rq.pop_front());
        if (req_valid && exp_rr) begin
            r = lookup(int'(req_idx), int'(req_idx2));
            rq.push_back(r);
        end
        if (wr) begin
            dict[2 * p1] = w_data;
            dv[2 * p1]   = 1'b1;
            p1           = (p1 + 1) % SZ;
        end
        if (wr2) begin
            dict[2 * p2 + 1] = w_data2;
            dv[2 * p2 + 1]   = 1'b1;
            p2               = (p2 + 1) % SZ;
        end
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic quiet();
        wr        = 1'b0;
        wr2       = 1'b0;
        w_data    = '0;
        w_data2   = '0;
        req_valid = 1'b0;
        req_idx   = '0;
        req_idx2  = '0;
        rsp_ready = 1'b1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        model_clear();
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    task automatic check_rsp(input string name, input logic [DW-1:0] d1,
                             input logic [DW-1:0] d2, input logic [1:0] err);
        chk({name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({name, "_data"}, rsp_data, d1);
        chk({name, "_data2"}, rsp_data2, d2);
        chk({name, "_err"}, {30'd0, rsp_err}, {30'd0, err});
    endtask

    vec_t vecs[6];

    initial begin
        quiet();
        do_reset();

        // Reset state and first cycle after reset.
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_rsp_err", {30'd0, rsp_err}, 32'd0);

        // Lookup of never-written entries.
        req_valid = 1'b1;
        req_idx   = 4'd3;
        req_idx2  = 4'd0;
        tick();
        check_rsp("unwritten", '0, '0, 2'b11);
        req_valid = 1'b0;
        tick();

        // Fill both banks, then table lookups back to back.
        for (int i = 0; i < SZ; i++) begin
            wr      = 1'b1;
            wr2     = 1'b1;
            w_data  = 32'hA0 + i;
            w_data2 = 32'hB0 + i;
            tick();
        end
        quiet();
        vecs[0] = '{0, 15, 32'hA0, 32'hB7, 2'b00};
        vecs[1] = '{1, 14, 32'hB0, 32'hA7, 2'b00};
        vecs[2] = '{3, 3, 32'hB1, 32'hB1, 2'b00};
        vecs[3] = '{6, 9, 32'hA3, 32'hB4, 2'b00};
        vecs[4] = '{12, 5, 32'hA6, 32'hB2, 2'b00};
        vecs[5] = '{8, 10, 32'hA4, 32'hA5, 2'b00};
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_idx   = IW'(vecs[i].idx);
            req_idx2  = IW'(vecs[i].idx2);
            tick();
            check_rsp($sformatf("vec%0d", i), vecs[i].d1, vecs[i].d2, vecs[i].err);
        end
        quiet();
        tick();

        // Pointer wraparound: 9th bank1 write overwrites slot 0.
        do_reset();
        for (int i = 0; i < SZ; i++) begin
            wr     = 1'b1;
            w_data = 32'h100 + i;
            tick();
        end
        w_data = 32'hDEAD;
        tick();
        quiet();
        req_valid = 1'b1;
        req_idx   = 4'd0;
        req_idx2  = 4'd2;
        tick();
        check_rsp("wrap", 32'hDEAD, 32'h101, 2'b00);
        quiet();

        // Refill slots 1..7 so the pointer returns to slot 0.
        for (int i = 1; i < SZ; i++) begin
            wr     = 1'b1;
            w_data = 32'h200 + i;
            tick();
        end
        // Same-cycle write and lookup of bank1[0]: old contents come back.
        wr        = 1'b1;
        w_data    = 32'h1234;
        req_valid = 1'b1;
        req_idx   = 4'd0;
        req_idx2  = 4'd0;
        tick();
        check_rsp("rbw_old", 32'hDEAD, 32'hDEAD, 2'b00);
        wr = 1'b0;
        tick();
        check_rsp("rbw_new", 32'h1234, 32'h1234, 2'b00);
        quiet();
        tick();

        // Backpressure: held response, blocked requests, then in-order drain.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_idx   = 4'd2;
        req_idx2  = 4'd4;
        tick();
        req_idx  = 4'd6;
        req_idx2 = 4'd6;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            tick();
            check_rsp($sformatf("bp_hold%0d", i), 32'h201, 32'h202, 2'b00);
        end
        rsp_ready = 1'b1;
        tick();
        check_rsp("drain0", 32'h203, 32'h203, 2'b00);
        req_idx  = 4'd8;
        req_idx2 = 4'd10;
        tick();
        check_rsp("drain1", 32'h204, 32'h205, 2'b00);
        req_valid = 1'b0;
        tick();
        chk("drain_empty", {31'd0, rsp_valid}, 32'd0);

        // Asynchronous reset while a response is pending.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_idx   = 4'd2;
        req_idx2  = 4'd4;
        tick();
        check_rsp("pre_async", 32'h201, 32'h202, 2'b00);
        #2 i_reset = 1'b1;
        #1;
        chk("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("async_rsp_data", rsp_data, '0);
        chk("async_rsp_data2", rsp_data2, '0);
        chk("async_rsp_err", {30'd0, rsp_err}, 32'd0);
        chk("async_req_ready", {31'd0, req_ready}, 32'd1);
        model_clear();
        @(negedge i_clk);
        i_reset = 1'b0;
        quiet();
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            wr        = 1'($urandom_range(0, 1));
            wr2       = 1'($urandom_range(0, 1));
            w_data    = $urandom;
            w_data2   = $urandom;
            req_valid = 1'($urandom_range(0, 1));
            req_idx   = IW'($urandom_range(0, WORDS - 1));
            req_idx2  = IW'($urandom_range(0, WORDS - 1));
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        quiet();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decomp_dict.md
DECOMP_DICT -- requirements
Module: decomp_dict

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-002 SHALL have parameter SIZE, default 8, entries per bank (power of two).
REQ-003 SHALL have parameter TOTAL_WORDS, default 16, equal to 2*SIZE; IW = clog2(TOTAL_WORDS).
REQ-004 SHALL have i_clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have i_reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have wr, wr2, inputs, 1 each: write strobes for bank 1 and bank 2.
REQ-007 SHALL have w_data, w_data2, inputs, DATA_WIDTH each: decoded words to insert.
REQ-008 SHALL have req_valid, input, 1, and req_ready, output, 1: lookup request handshake.
REQ-009 SHALL have req_idx, req_idx2, inputs, IW each: dictionary word indices for lane 1 and lane 2.
REQ-010 SHALL have rsp_valid, output, 1, and rsp_ready, input, 1: lookup response handshake.
REQ-011 SHALL have rsp_data, rsp_data2, outputs, DATA_WIDTH each: looked-up words.
REQ-012 SHALL have rsp_err, output, 2: bit0 = lane 1, bit1 = lane 2; set when the indexed entry was never written since reset.

Function
REQ-013 SHALL keep two banks of SIZE words, each with its own write pointer, so that it mirrors the compressor dictionary entry for entry.
REQ-014 SHALL, on wr, write w_data to bank1[ptr1], set that entry's valid bit, and advance ptr1, wrapping from SIZE-1 to 0; wr2 SHALL do the same independently for bank2 and ptr2.
REQ-015 SHALL accept wr and wr2 in the same cycle, updating both banks; a cycle with neither strobe SHALL leave both banks and both pointers unchanged.
REQ-016 SHALL map word index k to bank1[k>>1] when k[0]=0 and to bank2[k>>1] when k[0]=1, matching the compressor packing (index 0 = bank1[0], index 15 = bank2[SIZE-1]).
REQ-017 SHALL drive req_ready = !rsp_valid || rsp_ready.
REQ-018 SHALL accept a request when req_valid && req_ready, and SHALL register both lane results with rsp_valid=1 on the next edge (latency 1 cycle).
REQ-019 SHALL hold rsp_valid, rsp_data, rsp_data2 and rsp_err stable while rsp_valid && !rsp_ready.
REQ-020 SHALL clear rsp_valid when rsp_ready=1 and no new request is accepted in the same cycle.
REQ-021 SHALL support back-to-back accepts at one per cycle while rsp_ready stays at 1.
REQ-022 SHALL, when a lookup and a write target the same entry in the same cycle, return the pre-write contents and pre-write valid bit (read-before-write).
REQ-023 SHALL allow both lanes to read the same index in one request and return identical data.
REQ-024 SHALL, for an entry whose valid bit is 0, return rsp_data = 0 and set the lane's rsp_err bit.

Reset
REQ-025 SHALL, while i_reset=1, asynchronously clear all bank words to 0, all valid bits to 0, ptr1 and ptr2 to 0, rsp_valid to 0, rsp_data and rsp_data2 to 0, and rsp_err to 0.
REQ-026 SHALL, while i_reset=1, ignore writes and requests; a request in flight when reset asserts SHALL be dropped.
REQ-027 SHALL drive req_ready=1 in the first cycle after reset deasserts.

Structure
REQ-028 SHALL take DATA_WIDTH, SIZE and TOTAL_WORDS defaults and the index-to-bank/slot decode function from a shared package, decomp_pkg.
REQ-029 SHALL instantiate one sub-module, dict_bank, twice; each instance holds storage, valid bits, a wrapping write pointer and a combinational read port.
REQ-030 SHALL place the response register stage and handshake logic in decomp_dict itself.

Verification
REQ-031 The bench SHALL apply reset, then send a request with req_idx=3, req_idx2=0, and check rsp_valid=1 after 1 cycle with both data lanes 0 and rsp_err=2'b11.
REQ-032 The bench SHALL write wr&wr2 with 0xA0+i and 0xB0+i for i=0..7, request idx 0 and 15, and check rsp_data=0xA0, rsp_data2=0xB7, rsp_err=0.
REQ-033 The bench SHALL, after 8 bank1 writes, perform a 9th write of 0xDEAD and read idx 0, and check it returns 0xDEAD (pointer wraparound).
REQ-034 The bench SHALL write 0x1234 to bank1[0] while requesting idx 0 in the same cycle, check the response returns the old value, then re-request and check it returns 0x1234.
REQ-035 The bench SHALL hold rsp_ready=0 for 3 cycles with req_valid=1, and check req_ready=0 and the response stays stable; after rsp_ready=1, check exactly one response per cycle in request order.
REQ-036 The bench SHALL assert i_reset mid-stream while rsp_valid=1, and check all outputs go to 0 immediately with no clock edge required.
